// File: rtl/fifo_scan.sv
// Synchronous FIFO with fill thresholds, sticky overflow/underflow flags and a non-destructive scan port.
// Define FIFO_SCAN_FWFT_EN for first-word fall-through read_data; default is a registered read_data.
module fifo_scan #(
    parameter int DEPTH    = 4,
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = 3,
    parameter int AE_LEVEL = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clk_enable,
    input  logic                         write,
    input  logic [WIDTH-1:0]             write_data,
    input  logic                         read,
    output logic [WIDTH-1:0]             read_data,
    input  logic [$clog2(DEPTH)-1:0]     scan_index,
    output logic [WIDTH-1:0]             scan_data,
    output logic                         scan_valid,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_empty,
    output logic                         almost_full,
    output logic                         overflow,
    output logic                         underflow,
    input  logic                         clear_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   ZERO_C  = {(AW+1){1'b0}};
    localparam logic [AW:0]   ONE_C   = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   AF_C    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0]   AE_C    = (AW+1)'(AE_LEVEL);
    localparam logic [AW-1:0] PSTEP_C = {{(AW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             empty_q, full_q, ae_q, af_q;
    logic             pop_ok_s, push_ok_s;
    logic [AW-1:0]    scan_ptr_s;

    always_comb begin
        pop_ok_s    = read & ~empty_q;
        push_ok_s   = write & (~full_q | pop_ok_s);
        wr_ptr_d    = push_ok_s ? wr_ptr_q + PSTEP_C : wr_ptr_q;
        rd_ptr_d    = pop_ok_s  ? rd_ptr_q + PSTEP_C : rd_ptr_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
        // clear_err beats a same-cycle set
        if (clear_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            overflow_d  = overflow_q  | (write & full_q & ~read);
            underflow_d = underflow_q | (read & empty_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            count_q     <= ZERO_C;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            ae_q        <= 1'b1;
            af_q        <= 1'b0;
        end else if (clk_enable) begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            empty_q     <= (count_d == ZERO_C);
            full_q      <= (count_d == DEPTH_C);
            ae_q        <= (count_d <= AE_C);
            af_q        <= (count_d >= AF_C);
        end
    end

    // Storage is deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && clk_enable && push_ok_s) begin
            mem_q[wr_ptr_q] <= write_data;
        end
    end

`ifdef FIFO_SCAN_FWFT_EN
    assign read_data = empty_q ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];
`else
    logic [WIDTH-1:0] read_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            read_data_q <= {WIDTH{1'b0}};
        end else if (clk_enable && pop_ok_s) begin
            read_data_q <= mem_q[rd_ptr_q];
        end
    end

    assign read_data = read_data_q;
`endif

    assign scan_ptr_s   = rd_ptr_q + scan_index;
    assign scan_data    = mem_q[scan_ptr_s];
    assign scan_valid   = ({1'b0, scan_index} < count_q);

    assign count        = count_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign almost_empty = ae_q;
    assign almost_full  = af_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_scan.sv
// Randomised self-checking bench for fifo_scan against a queue-based reference model.
module tb_fifo_scan;

    localparam int DEPTH = 4;
    localparam int WIDTH = 8;
    localparam int AF    = 3;
    localparam int AE    = 1;

    logic       clk = 1'b0;
    logic       reset, clk_enable, write, read, clear_err;
    logic [7:0] write_data, read_data, scan_data;
    logic [1:0] scan_index;
    logic       scan_valid;
    logic [2:0] count;
    logic       empty, full, almost_empty, almost_full, overflow, underflow;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    bit         m_ov, m_un;
    logic [7:0] m_rd;

    fifo_scan #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable),
        .write(write), .write_data(write_data), .read(read), .read_data(read_data),
        .scan_index(scan_index), .scan_data(scan_data), .scan_valid(scan_valid),
        .count(count), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full),
        .overflow(overflow), .underflow(underflow), .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = mq.size();
        check_eq("count", 32'(count), 32'(n));
        check_eq("empty", 32'(empty), 32'(n == 0));
        check_eq("full", 32'(full), 32'(n == DEPTH));
        check_eq("almost_empty", 32'(almost_empty), 32'(n <= AE));
        check_eq("almost_full", 32'(almost_full), 32'(n >= AF));
        check_eq("overflow", 32'(overflow), 32'(m_ov));
        check_eq("underflow", 32'(underflow), 32'(m_un));
`ifdef FIFO_SCAN_FWFT_EN
        check_eq("read_data", 32'(read_data), (n > 0) ? 32'(mq[0]) : 32'd0);
`else
        check_eq("read_data", 32'(read_data), 32'(m_rd));
`endif
        for (int i = 0; i < DEPTH; i++) begin
            scan_index = 2'(i);
            #1;
            check_eq("scan_valid", 32'(scan_valid), 32'(i < n));
            if (i < n) check_eq("scan_data", 32'(scan_data), 32'(mq[i]));
        end
    endtask

    task automatic step(input bit rst, input bit en, input bit wr, input logic [7:0] wd,
                        input bit rd, input bit clr);
        bit was_full, was_empty, pop_ok, push_ok;
        reset = rst; clk_enable = en; write = wr; write_data = wd; read = rd; clear_err = clr;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_ov = 1'b0;
            m_un = 1'b0;
            m_rd = 8'h00;
        end else if (en) begin
            was_full  = (mq.size() == DEPTH);
            was_empty = (mq.size() == 0);
            pop_ok    = rd && !was_empty;
            push_ok   = wr && (!was_full || pop_ok);
            if (pop_ok) m_rd = mq.pop_front();
            if (push_ok) mq.push_back(wd);
            if (clr) begin
                m_ov = 1'b0;
                m_un = 1'b0;
            end else begin
                if (wr && was_full && !rd) m_ov = 1'b1;
                if (rd && was_empty) m_un = 1'b1;
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        scan_index = 2'd0;
        m_ov = 1'b0; m_un = 1'b0; m_rd = 8'h00;
        step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

        // fill to full
        step(1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h44, 1'b0, 1'b0);
        // dropped push, then clear
        step(1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        // drain plus one extra pop
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        // full with simultaneous read+write, then empty with read+write
        step(1'b0, 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h44, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h66, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
        // pointer wrap rounds
        for (int r = 0; r < 6; r++) begin
            step(1'b0, 1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
            step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
            step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        // random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
                 1'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 7) == 0);
        end
        // clock-enable hold, then reset while disabled
        step(1'b0, 1'b1, 1'b1, 8'hA1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 8'hA2, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        step(1'b0, 1'b0, 1'b1, 8'hB0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1, 8'hB1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
